// File: rtl/toggle_monitor_pkg.sv
// Shared types and default constants for the toggle-line monitor and its
// synchroniser/edge-detect helper.
package toggle_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        STUCK   = 2'd3
    } tm_state_e;

    // Plain vector aliases so the FSM register can stay a logic vector.
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ACQUIRE = ACQUIRE;
    localparam logic [1:0] ST_LOCKED  = LOCKED;
    localparam logic [1:0] ST_STUCK   = STUCK;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 1000;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TOL         = 0;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/toggle_monitor_if.sv
// Bundle of the toggle line, clear strobe and all status outputs of the monitor.
interface toggle_monitor_if
    import toggle_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             sig_in;
    logic             clear;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             err_stuck;
    logic             err_jitter;
    logic [7:0]       edge_count;
    logic [1:0]       state;

    modport master (
        input  sig_in,
        input  clear,
        output half_period,
        output meas_valid,
        output locked,
        output err_stuck,
        output err_jitter,
        output edge_count,
        output state
    );

    modport slave (
        output sig_in,
        output clear,
        input  half_period,
        input  meas_valid,
        input  locked,
        input  err_stuck,
        input  err_jitter,
        input  edge_count,
        input  state
    );

endinterface

// File: rtl/toggle_sync_edge.sv
// Multi-flop synchroniser for an asynchronous line plus a previous-value flop;
// edge_o is high for one cycle whenever the synchronised level changes.
module toggle_sync_edge
    import toggle_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic edge_o
);
    logic sync_q [SYNC_STAGES];
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= sig_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/toggle_monitor.sv
// Measures the half-period of an asynchronous toggle line, declares lock after
// a run of consistent measurements and raises sticky stuck/jitter flags.
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TOL        = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    toggle_monitor_if.master bus
);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
    localparam int                LOCK_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_COUNT - 1);

    logic edge_det;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [LOCK_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  half_period_q, half_period_d;
    logic              meas_valid_q, meas_valid_d;
    logic              err_stuck_q, err_stuck_d;
    logic              err_jitter_q, err_jitter_d;
    logic [7:0]        edge_count_q, edge_count_d;

    logic [CNT_W:0]    cnt_inc;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W-1:0]  meas_diff;
    logic              meas_match;
    logic              stuck_hit;
    logic              jitter_hit;

    toggle_sync_edge #(
        .SYNC_STAGES (DEF_SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (bus.sig_in),
        .edge_o (edge_det)
    );

    // One extra bit so the measurement saturates instead of wrapping.
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign meas       = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    assign meas_diff  = (meas >= prev_q) ? (meas - prev_q) : (prev_q - meas);
    assign meas_match = (meas_diff <= TOL_C);

    // Fires only on entry, so a clear while still stuck is not re-set forever.
    assign stuck_hit  = !edge_det && (cnt_q == CNT_MAX) && (state_q != ST_STUCK);

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        match_cnt_d   = match_cnt_q;
        half_period_d = half_period_q;
        meas_valid_d  = 1'b0;
        jitter_hit    = 1'b0;

        if (edge_det) begin
            cnt_d        = '0;
            edge_count_d = edge_count_q + 8'd1;
        end else begin
            cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CNT_W-1:0];
            edge_count_d = edge_count_q;
        end

        case (state_q)
            ST_IDLE, ST_STUCK: begin
                // The interval ending here has no valid start, so no measurement.
                if (edge_det) begin
                    state_d      = ST_ACQUIRE;
                    prev_valid_d = 1'b0;
                    match_cnt_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (edge_det) begin
                    meas_valid_d  = 1'b1;
                    half_period_d = meas;
                    prev_d        = meas;
                    prev_valid_d  = 1'b1;
                    if (prev_valid_q && meas_match) begin
                        match_cnt_d = match_cnt_q + LOCK_W'(1);
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_det) begin
                    meas_valid_d  = 1'b1;
                    half_period_d = meas;
                    prev_d        = meas;
                    if (!meas_match) begin
                        jitter_hit  = 1'b1;
                        match_cnt_d = '0;
                        state_d     = ST_ACQUIRE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stuck_hit) begin
            state_d      = ST_STUCK;
            prev_valid_d = 1'b0;
            match_cnt_d  = '0;
        end

        // Setting takes priority over a coincident clear.
        err_stuck_d  = (err_stuck_q  & ~bus.clear) | stuck_hit;
        err_jitter_d = (err_jitter_q & ~bus.clear) | jitter_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            match_cnt_q   <= '0;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            err_stuck_q   <= 1'b0;
            err_jitter_q  <= 1'b0;
            edge_count_q  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            match_cnt_q   <= match_cnt_d;
            half_period_q <= half_period_d;
            meas_valid_q  <= meas_valid_d;
            err_stuck_q   <= err_stuck_d;
            err_jitter_q  <= err_jitter_d;
            edge_count_q  <= edge_count_d;
        end
    end

    assign bus.half_period = half_period_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.err_stuck   = err_stuck_q;
    assign bus.err_jitter  = err_jitter_q;
    assign bus.edge_count  = edge_count_q;
    assign bus.state       = state_q;

endmodule

// File: doc/toggle_monitor.md
Name: toggle_monitor

Overview:
- Receive-side checker for a toggling status line, such as the clk/2 toggle driven out on a uio pin.
- Synchronises the asynchronous input and measures its half-period in clk cycles.
- Declares lock after a run of consistent measurements and flags stuck-line and jitter errors as sticky bits.
- Used on-chip for loopback self-test of uio signals and as a bring-up aid.

Parameters:
CNT_W, 16, width of half-period counter and measurement output
TIMEOUT, 1000, cycles without an edge before the line is declared stuck; must be < 2**CNT_W and ≥ 2
LOCK_COUNT, 4, consecutive matching measurements required to lock, ≥ 1
TOL, 0, max absolute difference (cycles) between successive measurements still counted as a match

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sig_in  input  1  asynchronous toggle line under test
clear  input  1  one-cycle pulse; clears err_stuck and err_jitter
half_period  output  CNT_W  last measured half-period in clk cycles
meas_valid  output  1  one-cycle pulse when half_period updates
locked  output  1  high while in LOCKED state
err_stuck  output  1  sticky: TIMEOUT reached with no edge
err_jitter  output  1  sticky: mismatch while LOCKED
edge_count  output  8  count of detected edges, wraps 255→0
state  output  2  FSM state, for debug

Behaviour:
- Reset: synchronous, active-high. All outputs and internal registers go to 0 on the clk edge where rst=1; state=IDLE. Reset mid-operation discards all history.
- Synchroniser and edge detect: s1<=sig_in; s2<=s1; p<=s2. edge = s2^p, combinational. An edge is seen 2 cycles after sig_in is first sampled changed.
- Run counter cnt:
  - On an edge cycle: cnt<=0, and the measurement m = cnt+1.
  - Otherwise: cnt increments, saturating at TIMEOUT-1.
  - Toggle on every sampled cycle gives m=1; toggle every 3 cycles gives m=3.
- edge_count increments on every edge cycle in every state, mod 256.
- Output timing: meas_valid, half_period and all state changes are registered; they appear the cycle after the edge cycle.
- FSM states:
  - IDLE (0): no reference edge yet. Edge → ACQUIRE; no measurement, prev invalid.
  - ACQUIRE (1): every edge produces a measurement (meas_valid=1, half_period<=m).
    - If prev is invalid: store prev<=m, match_cnt stays 0.
    - Else if |m-prev| ≤ TOL: match_cnt++; when it reaches LOCK_COUNT → LOCKED.
    - Else: match_cnt<=0.
    - Always prev<=m.
  - LOCKED (2): locked=1. Each edge produces a measurement.
    - Match: stay LOCKED.
    - Mismatch: err_jitter<=1, match_cnt<=0, prev<=m, → ACQUIRE.
  - STUCK (3): entered from any state when there is no edge and cnt==TIMEOUT-1.
    - Sets err_stuck<=1 and locked<=0; prev is invalidated.
    - Next edge → ACQUIRE with prev invalid; no meas_valid, because the interval overflowed.
- Sticky errors:
  - clear resets err_stuck and err_jitter.
  - If clear and an error set coincide in the same cycle, set wins.
  - clear does not affect FSM state, counters or edge_count.
- Edge on the same cycle cnt would reach TIMEOUT-1: the edge wins and no stuck is declared.
- Width rule: m is saturating; if cnt+1 would overflow CNT_W, m = 2**CNT_W-1. This cannot occur when TIMEOUT is legal.

Decomposition:
- Package toggle_monitor_pkg holds:
  - state enum: IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, STUCK=2'd3
  - default parameter constants
- Sub-module toggle_sync_edge: 2-FF synchroniser, previous-value flop and edge output. It is reusable for other uio loopback checkers.
- The counter, FSM and error flags stay in toggle_monitor.

Test Plan:
- sig_in toggled on every clk (defaults) → first meas_valid on edge 2 with half_period=1; locked=1 the cycle after edge 6; edge_count=6 at that point; no errors.
- sig_in toggled every 3 clks, locked, then one half-period of 4 clks → err_jitter=1, locked=0, state=ACQUIRE, half_period=4; relock 4 edges later with half_period=3.
- sig_in held constant from reset, TIMEOUT=20 → state=STUCK and err_stuck=1 on the cycle after cnt reaches 19; edge_count=0.
- After the stuck case, resume toggling every 2 clks → first edge gives no meas_valid; err_stuck stays 1 until clear; clear pulse → err_stuck=0 with state unaffected.
- Clear asserted on the same cycle err_jitter is set → err_jitter=1 (set wins).
- While LOCKED, assert rst for 1 cycle → all outputs 0 and state=IDLE the next cycle; 257 subsequent edges → edge_count=1.
